// File: rtl/lzd_norm_arbiter_if.sv
// rtl/lzd_norm_arbiter_if.sv - requester and response channels of lzd_norm_arbiter
//
// Groups the two requester handshakes (req/data/gnt) and the normalized
// response channel (valid/ready plus payload).
//   master : requester/consumer side (drives req*, data*, resp_ready)
//   slave  : lzd_norm_arbiter side (drives gnt*, resp_*)
interface lzd_norm_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_norm;
    logic [CNT_W-1:0]  resp_shift;
    logic              resp_zero;

    modport master (
        output req0, data0, req1, data1, resp_ready,
        input  gnt0, gnt1, resp_valid, resp_id, resp_norm, resp_shift, resp_zero
    );

    modport slave (
        input  req0, data0, req1, data1, resp_ready,
        output gnt0, gnt1, resp_valid, resp_id, resp_norm, resp_shift, resp_zero
    );
endinterface

// File: rtl/lzd_norm_arbiter.sv
// rtl/lzd_norm_arbiter.sv - round-robin sharing of one LZD and operand normalization
//
// Accepts one operand at a time from two requesters (round-robin when both
// ask), runs it through an external leading-zero detector, left-shifts it by
// the detected count and presents normalized value, shift and zero flag.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   bus      lzd_norm_arbiter_if.slave: req/data/gnt x2, response channel
//   lzd_in   operand driven to the external LZD (0 outside DETECT)
//   lzd_out  leading-zero count returned by the LZD (values > DATA_W clamp)
//   busy     high whenever an operand is in flight
module lzd_norm_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    lzd_norm_arbiter_if.slave    bus,
    output logic [DATA_W-1:0]    lzd_in,
    input  logic [CNT_W-1:0]     lzd_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] op_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              zero_reg;
    logic              id_reg;
    logic              prio;

    logic              any_req;
    logic              win_id;
    logic [DATA_W-1:0] win_data;
    logic [CNT_W-1:0]  cnt_in;
    logic              gnt0;
    logic              gnt1;
    logic              resp_valid;

    assign any_req  = bus.req0 | bus.req1;
    // A lone requester wins outright; prio only breaks ties.
    assign win_id   = (bus.req0 && bus.req1) ? prio : bus.req1;
    assign win_data = win_id ? bus.data1 : bus.data0;
    // A misbehaving LZD reporting more than DATA_W zeros is treated as all-zero.
    assign cnt_in   = (lzd_out > CNT_MAX) ? CNT_MAX : lzd_out;

    always_comb begin
        state_d    = state_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        lzd_in     = '0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are suppressed during reset so nothing is handed
                // off on an edge that will discard it.
                if (!rst && any_req) begin
                    gnt0    = ~win_id;
                    gnt1    = win_id;
                    state_d = DETECT;
                end
            end
            DETECT: begin
                lzd_in  = op_reg;
                state_d = NORM;
            end
            NORM: begin
                state_d = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_reg   <= '0;
            cnt_reg  <= '0;
            zero_reg <= 1'b0;
            id_reg   <= 1'b0;
            prio     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        op_reg <= win_data;
                        id_reg <= win_id;
                    end
                end
                DETECT: begin
                    cnt_reg <= cnt_in;
                end
                NORM: begin
                    // A full-width count means the operand was zero; shift
                    // result is forced to 0 rather than relying on shift
                    // overflow semantics.
                    if (cnt_reg >= CNT_MAX) begin
                        op_reg <= '0;
                    end else begin
                        op_reg <= op_reg << cnt_reg;
                    end
                    zero_reg <= (cnt_reg == CNT_MAX);
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        prio <= ~id_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.resp_valid = resp_valid;
    // Payload is exposed only in DONE so idle outputs read as zero.
    assign bus.resp_id    = resp_valid ? id_reg   : 1'b0;
    assign bus.resp_norm  = resp_valid ? op_reg   : '0;
    assign bus.resp_shift = resp_valid ? cnt_reg  : '0;
    assign bus.resp_zero  = resp_valid ? zero_reg : 1'b0;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_lzd_norm_arbiter.sv
// tb/tb_lzd_norm_arbiter.sv - scoreboard testbench for lzd_norm_arbiter
module tb_lzd_norm_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] lzd_in;
    logic [3:0] lzd_out;
    logic       busy;
    logic       force_big = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [13:0] sb[$];

    lzd_norm_arbiter_if #(.DATA_W(8), .CNT_W(4)) bus ();

    lzd_norm_arbiter #(.DATA_W(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .lzd_in  (lzd_in),
        .lzd_out (lzd_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lzd8(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 4'(7 - i);
        end
        return 4'd8;
    endfunction

    // External LZD stand-in; force_big makes it report an out-of-range count.
    assign lzd_out = force_big ? 4'hF : lzd8(lzd_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted response is popped and compared.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {bus.resp_id, bus.resp_norm, bus.resp_shift, bus.resp_zero}, 32'hDEAD);
            end else begin
                chk("resp", {bus.resp_id, bus.resp_norm, bus.resp_shift, bus.resp_zero}, sb.pop_front());
            end
        end
    end

    task automatic issue(input logic id, input logic [7:0] d, input logic push,
                         input logic [7:0] en, input logic [3:0] es, input logic ez,
                         input logic lat);
        int t;
        @(posedge clk); #1;
        if (id) begin bus.req1 = 1'b1; bus.data1 = d; end
        else    begin bus.req0 = 1'b1; bus.data0 = d; end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(id ? bus.gnt1 : bus.gnt0) && t < 50);
        if (t >= 50) begin
            chk("gnt_timeout", 0, 1);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            return;
        end
        if (push) sb.push_back({id, en, es, ez});
        @(posedge clk); #1;
        if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        if (lat) begin
            @(negedge clk);
            chk("lzd_in_detect", lzd_in, d);
            chk("busy_detect", busy, 1);
            chk("gnt_one_cycle", {bus.gnt0, bus.gnt1}, 0);
            chk("valid_lat1", bus.resp_valid, 0);
            @(negedge clk);
            chk("valid_lat2", bus.resp_valid, 0);
            @(negedge clk);
            chk("valid_lat3", bus.resp_valid, 1);
        end
    endtask

    // Both requesters held high; grants must alternate starting at 'first'.
    task automatic pair_run(input logic sync, input logic [7:0] d0, input logic [7:0] d1,
                            input int n, input logic first,
                            input logic [12:0] e0, input logic [12:0] e1);
        int  g;
        int  t;
        logic exp_id;
        if (sync) begin @(posedge clk); #1; end
        bus.req0 = 1'b1; bus.data0 = d0;
        bus.req1 = 1'b1; bus.data1 = d1;
        exp_id = first;
        g = 0;
        t = 0;
        while (g < n && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.gnt0 || bus.gnt1) begin
                if (bus.gnt0 && bus.gnt1) chk("both_gnt", 1, 0);
                chk("rr_gnt_id", bus.gnt1, exp_id);
                sb.push_back({bus.gnt1, bus.gnt1 ? e1 : e0});
                exp_id = ~exp_id;
                g++;
                if (g == n) begin
                    @(posedge clk); #1;
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
        end
        if (g < n) begin
            chk("rr_timeout", g, n);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.resp_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        bus.req0 = 1'b0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.data1 = '0;
        bus.resp_ready = 1'b1;

        // Reset and idle
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle_outs", {bus.resp_valid, bus.resp_norm, bus.resp_shift, bus.resp_zero,
                              bus.resp_id, lzd_in, busy, bus.gnt0, bus.gnt1}, 0);
        end

        // Single op: 0x16 has 3 leading zeros
        issue(1'b0, 8'h16, 1'b1, 8'hB0, 4'd3, 1'b0, 1'b1);
        drain();

        // Zero and boundaries on requester 1
        issue(1'b1, 8'h00, 1'b1, 8'h00, 4'd8, 1'b1, 1'b1);
        drain();
        issue(1'b1, 8'h80, 1'b1, 8'h80, 4'd0, 1'b0, 1'b1);
        drain();
        issue(1'b1, 8'h01, 1'b1, 8'h80, 4'd7, 1'b0, 1'b1);
        drain();

        // Round-robin: 0x20 -> shift 2, 0x04 -> shift 5
        pair_run(1'b1, 8'h20, 8'h04, 4, 1'b0, {8'h80, 4'd2, 1'b0}, {8'h80, 4'd5, 1'b0});
        drain();

        // Backpressure with requester 1 pending
        @(posedge clk); #1 bus.resp_ready = 1'b0;
        issue(1'b0, 8'h0F, 1'b1, 8'hF0, 4'd4, 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.data1 = 8'h02;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", bus.resp_valid, 1);
            chk("bp_payload", {bus.resp_id, bus.resp_norm, bus.resp_shift, bus.resp_zero},
                {1'b0, 8'hF0, 4'd4, 1'b0});
            chk("bp_no_gnt", {bus.gnt0, bus.gnt1}, 0);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        sb.push_back({1'b1, 8'h80, 4'd6, 1'b0});
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_idle", busy, 0);
        chk("bp_release_gnt1", {bus.gnt0, bus.gnt1}, 2'b01);
        @(posedge clk); #1 bus.req1 = 1'b0;
        drain();

        // Out-of-range LZD count clamps to 8
        force_big = 1'b1;
        issue(1'b0, 8'h40, 1'b1, 8'h00, 4'd8, 1'b1, 1'b1);
        drain();
        force_big = 1'b0;

        // Reset in NORM: prio is 1 here, must return to 0
        issue(1'b1, 8'h55, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req0 = 1'b1; bus.data0 = 8'h3C;
        bus.req1 = 1'b1; bus.data1 = 8'h01;
        @(negedge clk);
        chk("rst_mid_gnt", {bus.gnt0, bus.gnt1}, 0);
        @(posedge clk); #1;
        chk("rst_mid_valid", bus.resp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        pair_run(1'b0, 8'h3C, 8'h01, 2, 1'b0, {8'hF0, 4'd2, 1'b0}, {8'h80, 4'd7, 1'b0});
        drain();

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
